pa_ifu_spsram_ctrl: RTL and testbench

Access controller sitting directly upstream of the IFU 64-entry x 45-bit single-port SRAM macro (pa_spsram_64x45). Converts active-high read/write requests from IFU lookup and refill logic into the macro's active-low CEN/GWEN/WEN protocol. After reset, and on request, it runs an invalidation sweep that writes zero to every entry. It also returns read data with a valid strobe and holds that data afterwards.

---
 rtl/pa_ifu_spsram_ctrl.sv | 117 +++++++++++
 tb/tb_pa_ifu_spsram_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pa_ifu_spsram_ctrl.sv
// Access controller for the IFU 64x45 single-port SRAM macro: arbitrates read/write
// requests onto the active-low CEN/GWEN/WEN protocol and runs the invalidation sweep.
module pa_ifu_spsram_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 45
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_req,
  output logic                  inv_busy,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {
    RST  = 2'd0,
    INIT = 2'd1,
    IDLE = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [DATA_WIDTH-1:0] rd_hold_p1;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state     <= RST;
      sweep_cnt <= '0;
    end else begin
      case (state)
        RST: begin
          state     <= INIT;
          sweep_cnt <= '0;
        end
        INIT: begin
          if (inv_req) begin
            sweep_cnt <= '0;
          end else begin
            // Wrapping out of the last index ends the sweep with no extra cycle.
            sweep_cnt <= sweep_cnt + 1'b1;
            if (&sweep_cnt) state <= IDLE;
          end
        end
        IDLE: begin
          if (inv_req) begin
            state     <= INIT;
            sweep_cnt <= '0;
          end
        end
        default: begin
          state     <= RST;
          sweep_cnt <= '0;
        end
      endcase
    end
  end

  assign inv_busy = (state != IDLE);

  // A pending invalidation blocks both requesters for the cycle; write wins over read.
  always_comb begin
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (state == INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = sweep_cnt;
    end else if (state == IDLE && !inv_req) begin
      if (wr_req) begin
        wr_gnt    = 1'b1;
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = ~wr_mask;
        sram_a    = wr_idx;
        sram_d    = wr_data;
      end else if (rd_req) begin
        rd_gnt   = 1'b1;
        sram_cen = 1'b0;
        sram_a   = rd_idx;
      end
    end
  end

  // p1: macro Q returns one cycle after the grant; the hold register keeps it afterwards.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_vld     <= 1'b0;
      rd_hold_p1 <= '0;
    end else begin
      rd_vld <= rd_gnt;
      if (rd_vld) rd_hold_p1 <= sram_q;
    end
  end

  assign rd_data = rd_vld ? sram_q : rd_hold_p1;

endmodule

// File: tb/tb_pa_ifu_spsram_ctrl.sv
// Bench for pa_ifu_spsram_ctrl: behavioral macro model, directed stimulus,
// read-return scoreboard checked by a negedge monitor.
module tb_pa_ifu_spsram_ctrl;
  localparam int AW = 6;
  localparam int DW = 45;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inv_req, inv_busy;
  logic          rd_req, rd_gnt, rd_vld;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] rd_data;
  logic          wr_req, wr_gnt;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_data, wr_mask;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pa_ifu_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .inv_req(inv_req), .inv_busy(inv_busy),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
    .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_mask(wr_mask), .wr_gnt(wr_gnt),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Macro model: bit-masked write, registered read; Q goes to junk on idle cycles
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 45'h1A5A5A5A5A5 ^ DW'(i);
    sram_q = '0;
  end
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end else begin
      sram_q <= 45'h0DEADBEEF12;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_vld_unexpected: got rd_data %0h with no read outstanding at %0t",
                 rd_data, $time);
      end else begin
        exp_v = exp_q.pop_front();
        chk("rd_data", rd_data, exp_v);
      end
    end
  end

  task automatic drive(input logic rr, input logic [AW-1:0] ri, input logic wr,
                       input logic [AW-1:0] wi, input logic [DW-1:0] wd,
                       input logic [DW-1:0] wm, input logic inv);
    @(negedge clk);
    rd_req = rr; rd_idx = ri; wr_req = wr; wr_idx = wi;
    wr_data = wd; wr_mask = wm; inv_req = inv;
    #1;
  endtask

  task automatic idle_cyc();
    drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    chk("idle_rd_gnt", rd_gnt, 0);
    chk("idle_wr_gnt", wr_gnt, 0);
    chk("idle_cen", sram_cen, 1);
    chk("idle_a", sram_a, 0);
    chk("idle_d", sram_d, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic [DW-1:0] d,
                          input logic [DW-1:0] m, input logic [DW-1:0] exp_wen);
    drive(1'b0, '0, 1'b1, idx, d, m, 1'b0);
    chk("wr_gnt", wr_gnt, 1);
    chk("wr_rd_gnt", rd_gnt, 0);
    chk("wr_cen", sram_cen, 0);
    chk("wr_gwen", sram_gwen, 0);
    chk("wr_a", sram_a, idx);
    chk("wr_d", sram_d, d);
    chk("wr_wen", sram_wen, exp_wen);
  endtask

  task automatic do_read(input logic [AW-1:0] idx, input logic [DW-1:0] exp, input bit push);
    drive(1'b1, idx, 1'b0, '0, '0, '0, 1'b0);
    chk("rd_gnt", rd_gnt, 1);
    chk("rd_wr_gnt", wr_gnt, 0);
    chk("rd_cen", sram_cen, 0);
    chk("rd_gwen", sram_gwen, 1);
    chk("rd_wen", sram_wen, ONES);
    chk("rd_a", sram_a, idx);
    if (push) exp_q.push_back(exp);
  endtask

  task automatic sweep_range(input int lo, input int hi, input bit hold_req, input int inv_at);
    for (int i = lo; i <= hi; i++) begin
      drive(hold_req, 6'd7, hold_req, 6'd11, 45'h1234, ONES, (i == inv_at));
      chk("sw_busy", inv_busy, 1);
      chk("sw_cen", sram_cen, 0);
      chk("sw_gwen", sram_gwen, 0);
      chk("sw_wen", sram_wen, 0);
      chk("sw_d", sram_d, 0);
      chk("sw_a", sram_a, i);
      chk("sw_rd_gnt", rd_gnt, 0);
      chk("sw_wr_gnt", wr_gnt, 0);
    end
  endtask

  task automatic reset_seq();
    chk("rst_busy", inv_busy, 1);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_cen", sram_cen, 1);
    chk("rst_gwen", sram_gwen, 1);
    chk("rst_wen", sram_wen, ONES);
    chk("rst_a", sram_a, 0);
    chk("rst_d", sram_d, 0);
    @(negedge clk);
    rst_n = 1'b1; rd_req = 1'b1; wr_req = 1'b1; wr_data = 45'h1234; wr_mask = ONES;
    #1;
    chk("c0_busy", inv_busy, 1);
    chk("c0_cen", sram_cen, 1);
    chk("c0_wr_gnt", wr_gnt, 0);
    sweep_range(0, 63, 1'b1, -1);
    idle_cyc();
    chk("c65_busy", inv_busy, 0);
    chk("c65_gwen", sram_gwen, 1);
    chk("c65_wen", sram_wen, ONES);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; inv_req = 1'b0;
    rd_req = 1'b1; rd_idx = '0; wr_req = 1'b1; wr_idx = 6'd3;
    wr_data = 45'h1234; wr_mask = ONES;
    repeat (2) @(negedge clk);
    #1;
    reset_seq();

    // Full write then read of idx 5, checking hold after rd_vld falls
    do_write(6'd5, 45'h123456789A, ONES, '0);
    do_read(6'd5, 45'h123456789A, 1'b1);
    idle_cyc();
    chk("vld_after_gnt", rd_vld, 1);
    idle_cyc();
    chk("hold_vld", rd_vld, 0);
    chk("hold_data", rd_data, 45'h123456789A);

    // Masked write over a swept entry
    do_write(6'd9, ONES, 45'hF, 45'h1FFFFFFFFFF0);
    do_read(6'd9, 45'hF, 1'b1);
    idle_cyc();

    // Read/write collision: write wins, read retried next cycle
    drive(1'b1, 6'd5, 1'b1, 6'd20, 45'h0ABC, ONES, 1'b0);
    chk("col_wr_gnt", wr_gnt, 1);
    chk("col_rd_gnt", rd_gnt, 0);
    chk("col_a", sram_a, 20);
    chk("col_gwen", sram_gwen, 0);
    do_read(6'd5, 45'h123456789A, 1'b1);
    chk("col_no_vld", rd_vld, 0);
    do_read(6'd20, 45'hABC, 1'b1);
    do_write(6'd33, 45'h0F0F0F0F0F0, ONES, '0);
    do_read(6'd33, 45'h0F0F0F0F0F0, 1'b1);
    do_read(6'd9, 45'hF, 1'b1);
    idle_cyc();
    idle_cyc();

    // Invalidation in IDLE blocks requests, restart at index 30
    drive(1'b1, 6'd5, 1'b1, 6'd6, 45'h77, ONES, 1'b1);
    chk("inv_rd_gnt", rd_gnt, 0);
    chk("inv_wr_gnt", wr_gnt, 0);
    chk("inv_cen", sram_cen, 1);
    chk("inv_busy_idle", inv_busy, 0);
    sweep_range(0, 30, 1'b0, 30);
    sweep_range(0, 63, 1'b0, -1);
    idle_cyc();
    chk("inv_done_busy", inv_busy, 0);
    do_read(6'd5, '0, 1'b1);
    do_read(6'd20, '0, 1'b1);
    do_read(6'd33, '0, 1'b1);
    idle_cyc();

    // Asynchronous reset while a read return is in flight
    do_write(6'd3, 45'h1555, ONES, '0);
    do_read(6'd3, 45'h1555, 1'b1);
    idle_cyc();
    do_read(6'd3, '0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_vld", rd_vld, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_busy", inv_busy, 1);
    chk("arst_rd_gnt", rd_gnt, 0);
    repeat (2) @(negedge clk);
    #1;
    reset_seq();
    idle_cyc();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
